// File: rtl/hirose_digest_serializer.sv
// Captures the Hirose/PRESENT hash digest on the wrapper's end flag and streams it MSB-first
// as OUT_WIDTH-bit valid/ready words. Optional digest compare compiled in with `define DIGEST_CMP_EN.
module hirose_digest_serializer #(
   parameter int unsigned DIGEST_WIDTH = 128,
   parameter int unsigned OUT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hash_done,
   input  logic [DIGEST_WIDTH-1:0] hash_digest,
`ifdef DIGEST_CMP_EN
   input  logic [DIGEST_WIDTH-1:0] exp_digest,
   output logic                    match,
`endif
   output logic [OUT_WIDTH-1:0]    out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned N_WORDS = DIGEST_WIDTH / OUT_WIDTH;
   localparam int unsigned CNT_W   = $clog2(N_WORDS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]              state, state_nxt;
   logic [DIGEST_WIDTH-1:0] shreg, shreg_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic                    valid_nxt, last_nxt, busy_nxt, done_nxt;
`ifdef DIGEST_CMP_EN
   logic                    match_nxt;
`endif

   // Head of the shift register is the current word; it drains to zero by DONE.
   assign out_data = shreg[DIGEST_WIDTH-1 -: OUT_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef DIGEST_CMP_EN
         match     <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         cnt       <= cnt_nxt;
         out_valid <= valid_nxt;
         out_last  <= last_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
`ifdef DIGEST_CMP_EN
         match     <= match_nxt;
`endif
      end
   end

   // Next state; flag outputs are decoded from the next state so they leave a flop.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
`ifdef DIGEST_CMP_EN
      match_nxt = match;
`endif
      case (state)
         IDLE: begin
            if (hash_done) begin
               shreg_nxt = hash_digest;
               cnt_nxt   = '0;
               state_nxt = SEND;
`ifdef DIGEST_CMP_EN
               match_nxt = (hash_digest == exp_digest);
`endif
            end
         end
         SEND: begin
            if (out_ready) begin
               shreg_nxt = shreg << OUT_WIDTH;
               if (cnt == LAST_IDX) begin
                  state_nxt = DONE;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         DONE: begin
            // The end flag is a level; only its fall re-arms the serializer.
            if (!hash_done) begin
               state_nxt = IDLE;
`ifdef DIGEST_CMP_EN
               match_nxt = 1'b0;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase

      valid_nxt = (state_nxt == SEND);
      busy_nxt  = (state_nxt == SEND);
      last_nxt  = (state_nxt == SEND) && (cnt_nxt == LAST_IDX);
      done_nxt  = (state_nxt == DONE);
   end

endmodule

// File: tb/tb_hirose_digest_serializer.sv
// Directed bench for hirose_digest_serializer: reset abort, streaming, backpressure,
// level-trigger re-arm, post-capture digest changes and (with DIGEST_CMP_EN) digest compare.
module tb_hirose_digest_serializer;

   localparam int unsigned DW = 128;
   localparam int unsigned OW = 16;
   localparam int unsigned NW = DW / OW;

   logic          clk = 1'b0;
   logic          rst;
   logic          hash_done;
   logic [DW-1:0] hash_digest;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;
`ifdef DIGEST_CMP_EN
   logic [DW-1:0] exp_digest;
   logic          match;
`endif

   int errors = 0;
   int checks = 0;

   logic [OW-1:0] words[$];
   logic [OW-1:0] ref_words[NW] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF,
                                    16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
   localparam logic [DW-1:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   hirose_digest_serializer #(.DIGEST_WIDTH(DW), .OUT_WIDTH(OW)) dut (
      .clk         (clk),
      .rst         (rst),
      .hash_done   (hash_done),
      .hash_digest (hash_digest),
`ifdef DIGEST_CMP_EN
      .exp_digest  (exp_digest),
      .match       (match),
`endif
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Runs one capture + stream. Stalls stall_len cycles on word stall_at; optionally
   // corrupts the digest and drops hash_done after the first transfer. Returns cycles to done.
   task automatic stream(input logic [DW-1:0] dig, input int stall_at, input int stall_len,
                         input bit mutate, input logic exp_match, output int done_cyc);
      int idx = 0;
      int stalled = 0;
      int cyc = 0;
      int first_valid = -1;
      bit held = 1'b0;
      logic [OW-1:0] held_data = '0;
      words.delete();
      done_cyc = -1;
      hash_digest = dig;
      hash_done   = 1'b1;
      out_ready   = 1'b1;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (idx == stall_at && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (held) begin
               check("stall_hold_data", DW'(out_data), DW'(held_data));
               check("stall_hold_busy", DW'(busy), DW'(1'b1));
            end
            if (out_ready) begin
               words.push_back(out_data);
               check($sformatf("last_w%0d", idx), DW'(out_last), DW'(idx == NW - 1));
               idx++;
               held = 1'b0;
            end else begin
               held      = 1'b1;
               held_data = out_data;
            end
         end
`ifdef DIGEST_CMP_EN
         if (out_valid && idx == 1) check("match_send", DW'(match), DW'(exp_match));
`else
         if (exp_match !== 1'b0 && exp_match !== 1'b1) check("exp_match_known", DW'(0), DW'(1));
`endif
         if (mutate && idx >= 1) begin
            hash_digest = ~dig;
            hash_done   = 1'b0;
         end
      end
      check("first_valid_latency", DW'(first_valid), DW'(1));
      if (done_cyc < 0) check("done_timeout", DW'(0), DW'(1));
      check("word_count", DW'(words.size()), DW'(NW));
      for (int i = 0; i < NW && i < words.size(); i++)
         check($sformatf("word%0d", i), DW'(words[i]), DW'(dig[DW-1-OW*i -: OW]));
      check("done_valid_low", DW'(out_valid), DW'(0));
      check("done_busy_low", DW'(busy), DW'(0));
`ifdef DIGEST_CMP_EN
      check("match_done", DW'(match), DW'(exp_match));
`endif
   endtask

   task automatic rearm();
      hash_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rearm_done_low", DW'(done), DW'(0));
   endtask

   initial begin
      int dc;
      int vcount;
      rst         = 1'b1;
      hash_done   = 1'b0;
      hash_digest = '0;
      out_ready   = 1'b0;
`ifdef DIGEST_CMP_EN
      exp_digest  = D2;
`endif
      repeat (2) @(negedge clk);
      check("rst_valid", DW'(out_valid), DW'(0));
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_done", DW'(done), DW'(0));
      check("rst_last", DW'(out_last), DW'(0));
      check("rst_data", DW'(out_data), DW'(0));
      rst = 1'b0;
      @(negedge clk);
      check("idle_valid", DW'(out_valid), DW'(0));

      // Reset abort at word 3
      hash_digest = D2;
      hash_done   = 1'b1;
      out_ready   = 1'b1;
      repeat (4) @(negedge clk);
      check("pre_abort_word3", DW'(out_data), DW'(16'hCDEF));
      rst       = 1'b1;
      hash_done = 1'b0;
      @(negedge clk);
      check("abort_valid", DW'(out_valid), DW'(0));
      check("abort_busy", DW'(busy), DW'(0));
      check("abort_done", DW'(done), DW'(0));
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_stays_idle", DW'(out_valid), DW'(0));

      // Plain stream; also verify against the hand-written word table
      stream(D2, -1, 0, 1'b0, 1'b1, dc);
      check("nobp_done_cycle", DW'(dc), DW'(NW + 1));
      for (int i = 0; i < NW && i < words.size(); i++)
         check($sformatf("table_w%0d", i), DW'(words[i]), DW'(ref_words[i]));

      // Level held high after DONE: no second stream
      vcount = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) vcount++;
      end
      check("level_no_restream", DW'(vcount), DW'(0));
      check("level_done_held", DW'(done), DW'(1));
      rearm();

      // Re-arm with all-ones digest
      stream({DW{1'b1}}, -1, 0, 1'b0, 1'b0, dc);
      check("ones_w0", DW'(words.size() > 0 ? words[0] : 16'h0), DW'(16'hFFFF));
      rearm();

      // Backpressure on word 2 for 5 cycles
      stream(D2, 2, 5, 1'b0, 1'b1, dc);
      check("bp_done_cycle", DW'(dc), DW'(NW + 1 + 5));
      check("bp_word2", DW'(words.size() > 2 ? words[2] : 16'h0), DW'(16'h89AB));
      rearm();

      // Digest change and hash_done fall during SEND
      stream(D2, -1, 0, 1'b1, 1'b1, dc);
      @(negedge clk);
      check("fall_during_send_idle", DW'(done), DW'(0));
      hash_digest = D2;

`ifdef DIGEST_CMP_EN
      // Mismatch: same stream, match low
      exp_digest = D2 ^ DW'(1);
      stream(D2, -1, 0, 1'b0, 1'b0, dc);
      rearm();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
